// File: rtl/usb2_ts_packer.sv
// Packs 188-byte MPEG-TS packets (sync 0x47) into the EP3 bulk-IN endpoint buffer
// and commits the buffer when full, on an idle timeout, or when capture is disabled.
module usb2_ts_packer #(
    parameter int XFER_PKTS   = 10,
    parameter int TIMEOUT_CYC = 60000
) (
    input  logic        ep3_ext_clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [7:0]  ts_data,
    input  logic        ts_valid,
    input  logic        ts_sop,
    output logic [10:0] ep3_buf_in_addr,
    output logic [7:0]  ep3_buf_in_data,
    output logic        ep3_buf_in_wren,
    input  logic        ep3_buf_in_ready,
    output logic        ep3_buf_in_commit,
    output logic [10:0] ep3_buf_in_commit_len,
    input  logic        ep3_buf_in_commit_ack,
    output logic [15:0] stat_drop_cnt,
    output logic [1:0]  stat_state
);

    localparam logic [7:0]  SYNC_BYTE = 8'h47;
    localparam logic [7:0]  PKT_LEN   = 8'd188;
    localparam logic [7:0]  LAST_IDX  = 8'd187;
    localparam logic [3:0]  FULL_CNT  = 4'(XFER_PKTS);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t      state;
    logic [10:0] wr_ptr;
    logic [10:0] bnd_ptr;
    logic [7:0]  byte_idx;
    logic [3:0]  pkt_cnt;
    logic [15:0] idle_tmr;

    logic        sop_seen;
    logic        is_start;
    logic        bad_sop;
    logic        in_pkt;
    logic        can_accept;
    logic [10:0] wr_ptr_n;
    logic [10:0] bnd_ptr_n;
    logic [7:0]  byte_idx_n;
    logic [3:0]  pkt_cnt_n;
    logic [15:0] idle_tmr_n;
    logic        byte_we;
    logic [10:0] byte_addr;
    logic        part_n;
    logic        go_commit;
    logic        go_idle;
    logic [1:0]  drop_inc;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {15'd0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    assign sop_seen   = ts_valid & ts_sop;
    assign is_start   = sop_seen & (ts_data == SYNC_BYTE);
    assign bad_sop    = sop_seen & (ts_data != SYNC_BYTE);
    assign in_pkt     = (byte_idx != PKT_LEN);
    assign can_accept = (pkt_cnt != FULL_CNT);

    // Byte acceptance and exit decision for the current cycle
    always_comb begin
        wr_ptr_n   = wr_ptr;
        bnd_ptr_n  = bnd_ptr;
        byte_idx_n = byte_idx;
        pkt_cnt_n  = pkt_cnt;
        idle_tmr_n = idle_tmr;
        byte_we    = 1'b0;
        byte_addr  = wr_ptr;
        part_n     = 1'b0;
        go_commit  = 1'b0;
        go_idle    = 1'b0;
        drop_inc   = 2'd0;
        case (state)
            ST_IDLE, ST_COMMIT: begin
                if (sop_seen) drop_inc = 2'd1;
            end
            ST_FILL: begin
                if (!can_accept) begin
                    if (sop_seen) drop_inc = 2'd1;
                end else if (is_start) begin
                    // A start always lands at the last packet boundary, aborting any partial packet
                    byte_we    = 1'b1;
                    byte_addr  = bnd_ptr;
                    wr_ptr_n   = bnd_ptr + 11'd1;
                    byte_idx_n = 8'd1;
                    if (in_pkt) drop_inc = 2'd1;
                end else if (bad_sop) begin
                    drop_inc   = 2'd1;
                    byte_idx_n = PKT_LEN;
                    wr_ptr_n   = bnd_ptr;
                end else if (ts_valid && in_pkt) begin
                    byte_we   = 1'b1;
                    byte_addr = wr_ptr;
                    wr_ptr_n  = wr_ptr + 11'd1;
                    if (byte_idx == LAST_IDX) begin
                        byte_idx_n = PKT_LEN;
                        bnd_ptr_n  = wr_ptr + 11'd1;
                        pkt_cnt_n  = pkt_cnt + 4'd1;
                    end else begin
                        byte_idx_n = byte_idx + 8'd1;
                    end
                end
                idle_tmr_n = byte_we ? 16'd0 : ((pkt_cnt != 4'd0) ? idle_tmr + 16'd1 : idle_tmr);
                part_n     = (byte_idx_n != PKT_LEN);
                go_commit  = !can_accept
                           || ((idle_tmr == TMO_LAST) && (pkt_cnt != 4'd0))
                           || (!enable && (pkt_cnt_n != 4'd0));
                go_idle    = !go_commit && !enable;
                if ((go_commit || go_idle) && part_n) drop_inc = drop_inc + 2'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ep3_ext_clk or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= ST_IDLE;
            wr_ptr                <= 11'd0;
            bnd_ptr               <= 11'd0;
            byte_idx              <= PKT_LEN;
            pkt_cnt               <= 4'd0;
            idle_tmr              <= 16'd0;
            ep3_buf_in_addr       <= 11'd0;
            ep3_buf_in_data       <= 8'd0;
            ep3_buf_in_wren       <= 1'b0;
            ep3_buf_in_commit     <= 1'b0;
            ep3_buf_in_commit_len <= 11'd0;
            stat_drop_cnt         <= 16'd0;
        end else begin
            ep3_buf_in_wren <= 1'b0;
            stat_drop_cnt   <= sat_add16(stat_drop_cnt, drop_inc);
            case (state)
                ST_IDLE: begin
                    if (ep3_buf_in_ready && enable) begin
                        state    <= ST_FILL;
                        wr_ptr   <= 11'd0;
                        bnd_ptr  <= 11'd0;
                        pkt_cnt  <= 4'd0;
                        byte_idx <= PKT_LEN;
                        idle_tmr <= 16'd0;
                    end
                end
                ST_FILL: begin
                    bnd_ptr  <= bnd_ptr_n;
                    pkt_cnt  <= pkt_cnt_n;
                    idle_tmr <= idle_tmr_n;
                    // A byte of a packet that is being discarded on exit is not written
                    if (byte_we && !((go_commit || go_idle) && part_n)) begin
                        ep3_buf_in_wren <= 1'b1;
                        ep3_buf_in_addr <= byte_addr;
                        ep3_buf_in_data <= ts_data;
                    end
                    if (go_commit || go_idle) begin
                        wr_ptr   <= bnd_ptr_n;
                        byte_idx <= PKT_LEN;
                    end else begin
                        wr_ptr   <= wr_ptr_n;
                        byte_idx <= byte_idx_n;
                    end
                    if (go_commit) begin
                        state                 <= ST_COMMIT;
                        ep3_buf_in_commit     <= 1'b1;
                        ep3_buf_in_commit_len <= bnd_ptr_n;
                    end else if (go_idle) begin
                        state <= ST_IDLE;
                    end
                end
                ST_COMMIT: begin
                    if (ep3_buf_in_commit_ack) begin
                        ep3_buf_in_commit <= 1'b0;
                        state             <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign stat_state = state;

endmodule
